conv_layer_seq: RTL and testbench

Multi-layer sequencer in front of the convolution accelerator. Holds a small table of per-layer descriptors written by the host and, on `start`, walks through the layers. For each layer it drives the accelerator's configuration, `enable` and `conv_en` inputs. It snoops the weight, ifmap and readback stream handshakes to detect the end of the layer, then advances. It sits between the AXI-lite register block and the accelerator top, replacing direct host pokes of `conv_en`.

---
 rtl/conv_acc_pkg.sv | 34 +++
 rtl/desc_table.sv | 26 ++
 rtl/conv_layer_seq.sv | 196 +++++++++++++++++++
 tb/tb_conv_layer_seq.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_acc_pkg.sv
// rtl/conv_acc_pkg.sv - shared widths, sequencer state enum and layer descriptor
// Purpose: common definitions for the convolution accelerator front end.
// Ports: none (package).
package conv_acc_pkg;

   localparam int CFG_TENSOR_W   = 8;
   localparam int CFG_KERNEL_W   = 4;
   localparam int CFG_CHANNELS_W = 8;
   localparam int CFG_STRIDE_W   = 2;
   localparam int CFG_KNUMS_W    = 8;
   localparam int CFG_SHIFT_W    = 5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CFG,
      ST_PULSE,
      ST_LOAD,
      ST_DRAIN,
      ST_NEXT,
      ST_FIN
   } seq_state_t;

   typedef struct packed {
      logic [CFG_TENSOR_W-1:0]   tensor;
      logic [CFG_KERNEL_W-1:0]   kernel;
      logic [CFG_CHANNELS_W-1:0] channels;
      logic [CFG_STRIDE_W-1:0]   stride;
      logic [CFG_KNUMS_W-1:0]    knums;
      logic [CFG_SHIFT_W-1:0]    shift;
   } desc_t;

   localparam int DESC_W = $bits(desc_t);

endpackage

// File: rtl/desc_table.sv
// rtl/desc_table.sv - per-layer descriptor register file
// Purpose: DEPTH-entry descriptor store, one write port, one async read port.
// Ports: clk; we/waddr/wdata write port; raddr/rdata combinational read port.
module desc_table
   import conv_acc_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DESC_W-1:0]        wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DESC_W-1:0]        rdata
);

   // Contents are deliberately not reset: the host reloads them as needed.
   logic [DESC_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/conv_layer_seq.sv
// rtl/conv_layer_seq.sv - multi-layer sequencer driving the convolution accelerator
// Purpose: walks a host-written descriptor table, configures and starts the
//   accelerator per layer, and snoops stream handshakes to detect layer end.
// Ports: clk/rst; desc_* descriptor write; num_layers/start/abort run control;
//   acc_* registered accelerator config/enable/start; wt_*/if_*/rd_* snoops;
//   busy/done/err_tmo/cur_layer/layer_cycles status.
module conv_layer_seq
   import conv_acc_pkg::*;
#(
   parameter int TENSOR_W   = CFG_TENSOR_W,
   parameter int KERNEL_W   = CFG_KERNEL_W,
   parameter int CHANNELS_W = CFG_CHANNELS_W,
   parameter int STRIDE_W   = CFG_STRIDE_W,
   parameter int KNUMS_W    = CFG_KNUMS_W,
   parameter int SHIFT_W    = CFG_SHIFT_W,
   parameter int DEPTH      = 8,
   parameter int TMO_W      = 20
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     desc_we,
   input  logic [$clog2(DEPTH)-1:0] desc_idx,
   input  logic [TENSOR_W-1:0]      desc_tensor,
   input  logic [KERNEL_W-1:0]      desc_kernel,
   input  logic [CHANNELS_W-1:0]    desc_channels,
   input  logic [STRIDE_W-1:0]      desc_stride,
   input  logic [KNUMS_W-1:0]       desc_knums,
   input  logic [SHIFT_W-1:0]       desc_shift,
   input  logic [$clog2(DEPTH):0]   num_layers,
   input  logic                     start,
   input  logic                     abort,
   output logic [TENSOR_W-1:0]      acc_tensor_size,
   output logic [KERNEL_W-1:0]      acc_kernel_size,
   output logic [CHANNELS_W-1:0]    acc_channels,
   output logic [STRIDE_W-1:0]      acc_stride,
   output logic [KNUMS_W-1:0]       acc_kernel_nums,
   output logic [SHIFT_W-1:0]       acc_shift,
   output logic                     acc_enable,
   output logic                     acc_conv_en,
   input  logic                     wt_valid,
   input  logic                     wt_ready,
   input  logic                     wt_last,
   input  logic                     if_valid,
   input  logic                     if_ready,
   input  logic                     if_last,
   input  logic                     rd_valid,
   input  logic                     rd_ready,
   input  logic                     rd_last,
   output logic                     busy,
   output logic                     done,
   output logic                     err_tmo,
   output logic [$clog2(DEPTH)-1:0] cur_layer,
   output logic [TMO_W-1:0]         layer_cycles
);

   localparam int IW = $clog2(DEPTH);
   localparam logic [TMO_W-1:0] CNT_MAX = '1;

   seq_state_t        state;
   logic [IW:0]       nl_q;
   logic [TMO_W-1:0]  cnt;
   logic              wt_seen;
   logic              if_seen;
   desc_t             wr_desc;
   desc_t             rd_desc;
   logic [DESC_W-1:0] rd_bits;

   logic wt_hs, if_hs, rd_hs, load_done, cnt_sat, last_layer;

   assign wt_hs      = wt_valid & wt_ready & wt_last;
   assign if_hs      = if_valid & if_ready & if_last;
   assign rd_hs      = rd_valid & rd_ready & rd_last;
   // Include this cycle's handshakes so both streams may finish together.
   assign load_done  = (wt_seen | wt_hs) & (if_seen | if_hs);
   // True when the increment about to happen lands on all-ones.
   assign cnt_sat    = (cnt + TMO_W'(1)) == CNT_MAX;
   assign last_layer = ({1'b0, cur_layer} + (IW+1)'(1)) == nl_q;

   always_comb begin
      wr_desc          = '0;
      wr_desc.tensor   = CFG_TENSOR_W'(desc_tensor);
      wr_desc.kernel   = CFG_KERNEL_W'(desc_kernel);
      wr_desc.channels = CFG_CHANNELS_W'(desc_channels);
      wr_desc.stride   = CFG_STRIDE_W'(desc_stride);
      wr_desc.knums    = CFG_KNUMS_W'(desc_knums);
      wr_desc.shift    = CFG_SHIFT_W'(desc_shift);
   end

   assign rd_desc = rd_bits;

   desc_table #(.DEPTH(DEPTH)) u_desc_table (
      .clk   (clk),
      .we    (desc_we && (state == ST_IDLE)),
      .waddr (desc_idx),
      .wdata (wr_desc),
      .raddr (cur_layer),
      .rdata (rd_bits)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= ST_IDLE;
         nl_q            <= '0;
         cnt             <= '0;
         wt_seen         <= 1'b0;
         if_seen         <= 1'b0;
         acc_tensor_size <= '0;
         acc_kernel_size <= '0;
         acc_channels    <= '0;
         acc_stride      <= '0;
         acc_kernel_nums <= '0;
         acc_shift       <= '0;
         acc_enable      <= 1'b0;
         acc_conv_en     <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         err_tmo         <= 1'b0;
         cur_layer       <= '0;
         layer_cycles    <= '0;
      end else begin
         acc_conv_en <= 1'b0;
         done        <= 1'b0;
         if (abort && state != ST_IDLE) begin
            state      <= ST_IDLE;
            acc_enable <= 1'b0;
            busy       <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start && !abort) begin
                     nl_q      <= num_layers;
                     cur_layer <= '0;
                     err_tmo   <= 1'b0;
                     busy      <= 1'b1;
                     if (num_layers == '0) begin
                        state <= ST_FIN;
                        done  <= 1'b1;
                     end else begin
                        state <= ST_CFG;
                     end
                  end
               end
               ST_CFG: begin
                  acc_tensor_size <= TENSOR_W'(rd_desc.tensor);
                  acc_kernel_size <= KERNEL_W'(rd_desc.kernel);
                  acc_channels    <= CHANNELS_W'(rd_desc.channels);
                  acc_stride      <= STRIDE_W'(rd_desc.stride);
                  acc_kernel_nums <= KNUMS_W'(rd_desc.knums);
                  acc_shift       <= SHIFT_W'(rd_desc.shift);
                  acc_enable      <= 1'b1;
                  acc_conv_en     <= 1'b1;
                  cnt             <= '0;
                  wt_seen         <= 1'b0;
                  if_seen         <= 1'b0;
                  state           <= ST_PULSE;
               end
               ST_PULSE, ST_LOAD, ST_DRAIN: begin
                  cnt <= cnt + TMO_W'(1);
                  // Timeout takes priority over any normal progress this cycle.
                  if (cnt_sat) begin
                     err_tmo    <= 1'b1;
                     acc_enable <= 1'b0;
                     done       <= 1'b1;
                     state      <= ST_FIN;
                  end else if (state == ST_PULSE) begin
                     state <= ST_LOAD;
                  end else if (state == ST_LOAD) begin
                     if (wt_hs) wt_seen <= 1'b1;
                     if (if_hs) if_seen <= 1'b1;
                     if (load_done) state <= ST_DRAIN;
                  end else if (rd_hs) begin
                     state <= ST_NEXT;
                  end
               end
               ST_NEXT: begin
                  layer_cycles <= cnt;
                  acc_enable   <= 1'b0;
                  if (last_layer) begin
                     state <= ST_FIN;
                     done  <= 1'b1;
                  end else begin
                     cur_layer <= cur_layer + IW'(1);
                     state     <= ST_CFG;
                  end
               end
               ST_FIN: begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_conv_layer_seq.sv
// tb/tb_conv_layer_seq.sv - self-checking bench for conv_layer_seq
`timescale 1ns/1ps
module tb_conv_layer_seq;

   localparam int DEPTH = 8;
   localparam int TMO_W = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic       desc_we = 0;
   logic [2:0] desc_idx = 0;
   logic [7:0] desc_tensor = 0;
   logic [3:0] desc_kernel = 0;
   logic [7:0] desc_channels = 0;
   logic [1:0] desc_stride = 0;
   logic [7:0] desc_knums = 0;
   logic [4:0] desc_shift = 0;
   logic [3:0] num_layers = 0;
   logic       start = 0, abort = 0;
   logic [7:0] acc_tensor_size;
   logic [3:0] acc_kernel_size;
   logic [7:0] acc_channels;
   logic [1:0] acc_stride;
   logic [7:0] acc_kernel_nums;
   logic [4:0] acc_shift;
   logic       acc_enable, acc_conv_en;
   logic       wt_valid = 0, wt_ready = 0, wt_last = 0;
   logic       if_valid = 0, if_ready = 0, if_last = 0;
   logic       rd_valid = 0, rd_ready = 0, rd_last = 0;
   logic       busy, done, err_tmo;
   logic [2:0] cur_layer;
   logic [TMO_W-1:0] layer_cycles;

   always #5 clk = ~clk;

   conv_layer_seq #(.TMO_W(TMO_W)) dut (
      .clk(clk), .rst(rst),
      .desc_we(desc_we), .desc_idx(desc_idx),
      .desc_tensor(desc_tensor), .desc_kernel(desc_kernel),
      .desc_channels(desc_channels), .desc_stride(desc_stride),
      .desc_knums(desc_knums), .desc_shift(desc_shift),
      .num_layers(num_layers), .start(start), .abort(abort),
      .acc_tensor_size(acc_tensor_size), .acc_kernel_size(acc_kernel_size),
      .acc_channels(acc_channels), .acc_stride(acc_stride),
      .acc_kernel_nums(acc_kernel_nums), .acc_shift(acc_shift),
      .acc_enable(acc_enable), .acc_conv_en(acc_conv_en),
      .wt_valid(wt_valid), .wt_ready(wt_ready), .wt_last(wt_last),
      .if_valid(if_valid), .if_ready(if_ready), .if_last(if_last),
      .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
      .busy(busy), .done(done), .err_tmo(err_tmo),
      .cur_layer(cur_layer), .layer_cycles(layer_cycles)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int n_pulse = 0;
   int n_done  = 0;

   // Reference descriptor table: what the host believes each slot holds.
   logic [7:0] m_tensor [DEPTH];
   logic [3:0] m_kernel [DEPTH];
   logic [7:0] m_ch     [DEPTH];
   logic [1:0] m_stride [DEPTH];
   logic [7:0] m_knums  [DEPTH];
   logic [4:0] m_shift  [DEPTH];

   always @(negedge clk) begin
      if (acc_conv_en === 1'b1) n_pulse++;
      if (done === 1'b1) n_done++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      desc_we = 0; start = 0; abort = 0;
      {wt_valid, wt_ready, wt_last} = 3'b000;
      {if_valid, if_ready, if_last} = 3'b000;
      {rd_valid, rd_ready, rd_last} = 3'b000;
   endtask

   task automatic write_desc(input int idx, input logic [7:0] t, input logic [3:0] k,
                             input logic [7:0] c, input logic [1:0] s,
                             input logic [7:0] kn, input logic [4:0] sh);
      desc_idx = 3'(idx); desc_tensor = t; desc_kernel = k; desc_channels = c;
      desc_stride = s; desc_knums = kn; desc_shift = sh; desc_we = 1;
      tick;
      desc_we = 0;
      m_tensor[idx] = t; m_kernel[idx] = k; m_ch[idx] = c;
      m_stride[idx] = s; m_knums[idx] = kn; m_shift[idx] = sh;
   endtask

   task automatic rand_desc(input int idx);
      write_desc(idx, 8'($urandom), 4'($urandom), 8'($urandom), 2'($urandom),
                 8'($urandom), 5'($urandom));
   endtask

   task automatic check_cfg(input int l);
      check("cur_layer", 32'(cur_layer), 32'(l));
      check("cfg_tensor", 32'(acc_tensor_size), 32'(m_tensor[l]));
      check("cfg_kernel", 32'(acc_kernel_size), 32'(m_kernel[l]));
      check("cfg_channels", 32'(acc_channels), 32'(m_ch[l]));
      check("cfg_stride", 32'(acc_stride), 32'(m_stride[l]));
      check("cfg_knums", 32'(acc_kernel_nums), 32'(m_knums[l]));
      check("cfg_shift", 32'(acc_shift), 32'(m_shift[l]));
   endtask

   task automatic noise_load;
      wt_valid = 1'($urandom); wt_last = 1'($urandom); wt_ready = 1'($urandom);
      if (wt_valid && wt_last) wt_ready = 1'b0;
      if_valid = 1'($urandom); if_last = 1'($urandom); if_ready = 1'($urandom);
      if (if_valid && if_last) if_ready = 1'b0;
      rd_valid = 1'($urandom); rd_ready = 1'($urandom); rd_last = 1'($urandom);
   endtask

   // Runs n layers from start to idle, checking exact cycle timing per layer.
   task automatic run_seq(input int n, input bit rd_in_load, input bit same_cycle);
      int gw, gi, m, dr, lc;
      num_layers = 4'(n); start = 1;
      tick;
      start = 0;
      check("cfg_busy", 32'(busy), 1);
      check("cfg_enable_low", 32'(acc_enable), 0);
      check("cfg_no_pulse", 32'(acc_conv_en), 0);
      check("err_cleared", 32'(err_tmo), 0);
      tick;
      for (int l = 0; l < n; l++) begin
         check("pulse", 32'(acc_conv_en), 1);
         check("enable_on", 32'(acc_enable), 1);
         check_cfg(l);
         if (same_cycle) begin
            gw = $urandom_range(0, 2); gi = gw;
         end else begin
            gw = $urandom_range(0, 3); gi = $urandom_range(0, 3);
         end
         m  = (gw > gi) ? gw : gi;
         dr = $urandom_range(0, 4);
         lc = 1 + (m + 1) + (dr + 1);
         tick;
         for (int k = 0; k <= m; k++) begin
            if (k == 0) check("pulse_one_cycle", 32'(acc_conv_en), 0);
            noise_load();
            if (k == gw) {wt_valid, wt_ready, wt_last} = 3'b111;
            if (k == gi) {if_valid, if_ready, if_last} = 3'b111;
            if (rd_in_load && k == 0) {rd_valid, rd_ready, rd_last} = 3'b111;
            tick;
         end
         for (int s = 0; s <= dr; s++) begin
            check("drain_busy", 32'(busy), 1);
            check("drain_enable", 32'(acc_enable), 1);
            check("drain_no_done", 32'(done), 0);
            wt_valid = 1'($urandom); wt_ready = 1'($urandom); wt_last = 1'($urandom);
            if_valid = 1'($urandom); if_ready = 1'($urandom); if_last = 1'($urandom);
            rd_valid = 1'($urandom); rd_last = 1'($urandom); rd_ready = 1'b0;
            start = 1'($urandom); num_layers = 4'($urandom);
            desc_we = 1; desc_idx = 3'($urandom); desc_tensor = 8'($urandom);
            desc_knums = 8'($urandom);
            if (s == dr) {rd_valid, rd_ready, rd_last} = 3'b111;
            tick;
         end
         idle_inputs();
         check("next_enable", 32'(acc_enable), 1);
         check("next_busy", 32'(busy), 1);
         tick;
         check("gap_enable_low", 32'(acc_enable), 0);
         check("layer_cycles", 32'(layer_cycles), 32'(lc));
         if (l == n - 1) begin
            check("fin_done", 32'(done), 1);
            check("fin_busy", 32'(busy), 1);
            tick;
            check("idle_done_low", 32'(done), 0);
            check("idle_busy_low", 32'(busy), 0);
         end else begin
            check("cfg_no_done", 32'(done), 0);
            check("cur_layer_step", 32'(cur_layer), 32'(l + 1));
            tick;
         end
      end
   endtask

   initial begin
      int p0, d0;
      idle_inputs();
      #12;
      check("rst_busy", 32'(busy), 0);
      check("rst_enable", 32'(acc_enable), 0);
      check("rst_conv_en", 32'(acc_conv_en), 0);
      check("rst_done", 32'(done), 0);
      check("rst_err", 32'(err_tmo), 0);
      check("rst_cur_layer", 32'(cur_layer), 0);
      check("rst_cycles", 32'(layer_cycles), 0);
      check("rst_tensor", 32'(acc_tensor_size), 0);
      tick;
      rst = 0;
      tick;

      for (int i = 0; i < DEPTH; i++) rand_desc(i);
      write_desc(0, 8'd8, 4'd3, 8'd2, 2'd1, 8'd4, 5'd5);
      write_desc(1, 8'd6, 4'd5, 8'd3, 2'd2, 8'd7, 5'd9);

      // Two directed layers.
      p0 = n_pulse; d0 = n_done;
      run_seq(2, 1'b0, 1'b0);
      check("two_layer_pulses", 32'(n_pulse - p0), 2);
      check("two_layer_done", 32'(n_done - d0), 1);

      // Same-cycle loads, then rd_last during LOAD.
      run_seq(2, 1'b0, 1'b1);
      run_seq(3, 1'b1, 1'b0);

      // Zero layers: done the cycle after start, no pulse.
      p0 = n_pulse;
      num_layers = 0; start = 1;
      tick;
      start = 0;
      check("zero_done", 32'(done), 1);
      check("zero_busy", 32'(busy), 1);
      tick;
      check("zero_done_once", 32'(done), 0);
      check("zero_idle", 32'(busy), 0);
      check("zero_no_pulse", 32'(n_pulse - p0), 0);

      // Abort and start together in IDLE.
      num_layers = 1; start = 1; abort = 1;
      tick;
      idle_inputs();
      check("abort_start_idle", 32'(busy), 0);
      tick;
      check("abort_start_no_pulse", 32'(acc_conv_en), 0);

      // Abort mid-LOAD with a dropped descriptor write during the run.
      d0 = n_done;
      num_layers = 2; start = 1;
      tick;
      start = 0;
      write_desc(1, ~m_tensor[1], ~m_kernel[1], ~m_ch[1], ~m_stride[1], ~m_knums[1], ~m_shift[1]);
      // That write must not land; restore the model to the pre-run contents.
      m_tensor[1] = ~m_tensor[1]; m_kernel[1] = ~m_kernel[1]; m_ch[1] = ~m_ch[1];
      m_stride[1] = ~m_stride[1]; m_knums[1] = ~m_knums[1]; m_shift[1] = ~m_shift[1];
      check("abort_run_pulse", 32'(acc_conv_en), 1);
      tick;
      abort = 1;
      tick;
      abort = 0;
      check("abort_busy", 32'(busy), 0);
      check("abort_enable", 32'(acc_enable), 0);
      tick;
      check("abort_no_done", 32'(n_done - d0), 0);
      run_seq(2, 1'b0, 1'b0);

      // Timeout: readback stalled forever.
      num_layers = 1; start = 1;
      tick;
      start = 0;
      tick;
      check("tmo_pulse", 32'(acc_conv_en), 1);
      tick;
      {wt_valid, wt_ready, wt_last} = 3'b111;
      {if_valid, if_ready, if_last} = 3'b111;
      {rd_valid, rd_ready, rd_last} = 3'b101;
      tick;
      {wt_valid, wt_ready, wt_last} = 3'b000;
      {if_valid, if_ready, if_last} = 3'b000;
      for (int i = 0; i < 60; i++) tick;
      check("tmo_not_yet", 32'(err_tmo), 0);
      check("tmo_enable_before", 32'(acc_enable), 1);
      tick;
      check("tmo_err", 32'(err_tmo), 1);
      check("tmo_enable_off", 32'(acc_enable), 0);
      check("tmo_done", 32'(done), 1);
      tick;
      idle_inputs();
      check("tmo_idle", 32'(busy), 0);
      check("tmo_sticky", 32'(err_tmo), 1);
      run_seq(1, 1'b0, 1'b0);

      // Randomized descriptor tables and layer counts, including the full table.
      for (int it = 0; it < 4; it++) begin
         for (int i = 0; i < DEPTH; i++) rand_desc(i);
         run_seq((it == 3) ? DEPTH : $urandom_range(1, DEPTH), it[0], it == 2);
      end

      // Asynchronous reset mid-DRAIN.
      num_layers = 1; start = 1;
      tick;
      start = 0;
      tick;
      tick;
      {wt_valid, wt_ready, wt_last} = 3'b111;
      {if_valid, if_ready, if_last} = 3'b111;
      tick;
      idle_inputs();
      check("pre_rst_busy", 32'(busy), 1);
      #2;
      rst = 1;
      #1;
      check("arst_busy", 32'(busy), 0);
      check("arst_enable", 32'(acc_enable), 0);
      check("arst_done", 32'(done), 0);
      check("arst_cycles", 32'(layer_cycles), 0);
      check("arst_tensor", 32'(acc_tensor_size), 0);
      check("arst_knums", 32'(acc_kernel_nums), 0);
      check("arst_cur_layer", 32'(cur_layer), 0);
      tick;
      tick;
      rst = 0;
      tick;
      run_seq(2, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
